// File: rtl/gsram_pkg.sv
// Shared definitions for the 10x10 grid SRAM and its scan reader.
package gsram_pkg;

  localparam int unsigned GRID_ROWS = 10;
  localparam int unsigned GRID_COLS = 10;
  localparam int unsigned GRID_DW   = 16;
  localparam int unsigned GRID_AW   = 4;

  typedef logic [GRID_AW-1:0] grid_idx_t;
  typedef logic [GRID_DW-1:0] grid_word_t;

  // Explicit encodings keep the state values stable for legacy tooling.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/gsram_scan_fifo2.sv
// Two-entry FIFO carrying {last, row, col, data} for the scan reader.
// Storage is reset so the head reads as zero out of reset.
module gsram_scan_fifo2
  import gsram_pkg::*;
#(
  parameter int unsigned W = GRID_DW + 2 * GRID_AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Storage, pointers and occupancy; the caller never pushes when full without popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/gsram_scan_reader.sv
// Read-side scan controller for the grid SRAM. Walks every cell once per start,
// absorbs the one-cycle SRAM read latency and streams elements with coordinates.
// Define GSRAM_SCAN_COLMAJOR_EN for column-major order (row index advances first).
module gsram_scan_reader
  import gsram_pkg::*;
#(
  parameter int unsigned ROWS = GRID_ROWS,
  parameter int unsigned COLS = GRID_COLS,
  parameter int unsigned DW   = GRID_DW,
  parameter int unsigned AW   = GRID_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sram_we,
  output logic [AW-1:0] sram_row,
  output logic [AW-1:0] sram_col,
  input  logic [DW-1:0] sram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_row,
  output logic [AW-1:0] out_col,
  output logic          out_last
);

  localparam int unsigned   FW      = DW + 2 * AW + 1;
  localparam logic [AW-1:0] ROW_MAX = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_MAX = AW'(COLS - 1);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          inflight_q;
  logic [AW-1:0] cap_row_q, cap_col_q;
  logic          cap_last_q;
  logic [1:0]    fifo_count;
  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic          pop, issue, credit_ok, last_addr;

  assign sram_we   = 1'b0;
  assign sram_row  = row_q;
  assign sram_col  = col_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  assign fifo_wdata = {cap_last_q, cap_row_q, cap_col_q, sram_rdata};
  assign {out_last, out_row, out_col, out_data} = fifo_rdata;

  // Occupancy next cycle, counting the read already in flight, must leave room for one more.
  assign credit_ok = (3'(fifo_count) + 3'(inflight_q)) <= (3'(pop) + 3'd1);
  assign issue     = (state_q == SCAN) && credit_ok;
  assign last_addr = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // The final element leaves the FIFO with nothing behind it.
  assign done = (state_q == DRAIN) && pop && out_last && !inflight_q && (fifo_count == 2'd1);

  // Scan sequencing: leave SCAN after the last address issues, leave DRAIN on the last pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (issue && last_addr) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address walk: clear on start, advance on each issue, hold on the final cell.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE && start) begin
      row_d = '0;
      col_d = '0;
    end else if (issue && !last_addr) begin
`ifdef GSRAM_SCAN_COLMAJOR_EN
      if (row_q == ROW_MAX) begin
        row_d = '0;
        col_d = col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  // State, address and the coordinates travelling alongside the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
      cap_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= issue;
      if (issue) begin
        cap_row_q  <= row_q;
        cap_col_q  <= col_q;
        cap_last_q <= last_addr;
      end
    end
  end

  gsram_scan_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_gsram_scan_reader.sv
// Directed bench for gsram_scan_reader with a behavioural grid SRAM holding mem[r][c] = r*16+c.
module tb_gsram_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, sram_we;
  logic [3:0]  sram_row, sram_col;
  logic [15:0] sram_rdata = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_row, out_col;
  logic        out_last;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          s_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          first_valid_cyc = -1;
  int          first_pop_cyc = 0;
  int          last_pop_cyc = 0;
  int          max_occ = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  logic        busy_chk = 1'b0;
  logic        prev_hold = 1'b0;
  logic [25:0] prev_out = '0;
  logic [24:0] got_q[$];

  gsram_scan_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .sram_we    (sram_we),
    .sram_row   (sram_row),
    .sram_col   (sram_col),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Grid SRAM: one-cycle read latency, contents r*16+c.
  always @(posedge clk) sram_rdata <= {8'h00, sram_row, sram_col};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [24:0] exp_elem(input int k);
    int r, c;
`ifdef GSRAM_SCAN_COLMAJOR_EN
    r = k % 10;
    c = k / 10;
`else
    r = k / 10;
    c = k % 10;
`endif
    return {(k == 99), 4'(r), 4'(c), 16'(r * 16 + c)};
  endfunction

  // Ready driver, changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor on the falling edge: records pops, done pulses, occupancy and hold stability.
  always @(negedge clk) begin
    if (busy_chk) begin
      check("busy_fall", busy, 0);
      busy_chk = 1'b0;
    end
    if (rst_n) begin
      if (prev_hold)
        check("hold_stable", {out_valid, out_last, out_row, out_col, out_data}, prev_out);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (got_q.size() == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        got_q.push_back({out_last, out_row, out_col, out_data});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 1);
        busy_chk = 1'b1;
      end
      if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, out_last, out_row, out_col, out_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {busy, done, sram_we, out_valid, out_last, sram_row, sram_col}, 0);
    check({tag, "_out"}, {out_data, out_row, out_col}, 0);
  endtask

  task automatic start_scan();
    got_q.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
    max_occ = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, (done_cnt != 0), 1);
    repeat (5) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_count"}, got_q.size(), 100);
    for (int k = 0; k < got_q.size() && k < 100; k++) check(tag, got_q[k], exp_elem(k));
  endtask

  initial begin
    // Reset state, before any clock edge.
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full-ready scan: latency, throughput and done timing.
    ready_mode = 0;
    start_scan();
    wait_done("full");
    compare_run("full");
    check("first_valid_lat", first_valid_cyc - s_cyc, 3);
    check("done_lat", done_cyc - s_cyc, 102);
    check("no_bubbles", last_pop_cyc - first_pop_cyc, 99);
    check("sram_we", sram_we, 0);

    // Backpressure: hold the head for 20 cycles, address may run at most 2 ahead.
    begin
      int n = 0;
      ready_mode = 2;
      start_scan();
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("hold_first_valid", out_valid, 1);
      for (int i = 0; i < 20; i++) begin
        check("hold_data", {out_row, out_col, out_data}, 0);
        check("hold_addr", ((32'(sram_row) + 32'(sram_col)) <= 2) &&
              (sram_row == 4'd0 || sram_col == 4'd0), 1);
        @(negedge clk);
      end
      ready_mode = 0;
      wait_done("hold");
      compare_run("hold");
      check("hold_max_occ", (max_occ <= 2), 1);
    end

    // Random backpressure yields the same sequence.
    ready_mode = 1;
    start_scan();
    wait_done("rand");
    ready_mode = 0;
    compare_run("rand");
    check("rand_max_occ", (max_occ <= 2), 1);

    // A second start in the middle of a scan is ignored.
    start_scan();
    repeat (30) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("restart");
    compare_run("restart");

    // Asynchronous reset mid-scan, then a clean full scan.
    begin
      int n = 0;
      start_scan();
      while (got_q.size() < 40 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach40", (got_q.size() >= 40), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      rst_n = 1'b1;
      start_scan();
      wait_done("after_abort");
      compare_run("after_abort");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
